// File: rtl/synth_pkg.sv
// Shared waveform codes, FSM state encodings and helpers for the tone mixer.
// Envelope ramp enabled by defining POLY_TONE_ENV_EN.
package synth_pkg;

  typedef enum logic [1:0] {
    WAVE_SQUARE = 2'b00,
    WAVE_SAW    = 2'b01,
    WAVE_TRI    = 2'b10,
    WAVE_OFF    = 2'b11
  } wave_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_CALC = 2'b01,
    ST_ADD  = 2'b10,
    ST_OUT  = 2'b11
  } state_e;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < v) r = i + 1;
    return r;
  endfunction

endpackage

// File: rtl/tone_wave_shaper.sv
// Combinational waveform shaper: top phase bits + waveform code -> signed wave.
// Time-shared across all voices by the mixer.
module tone_wave_shaper
  import synth_pkg::*;
#(
  parameter int PHASE_W  = 24,
  parameter int SAMPLE_W = 16
) (
  input  logic [PHASE_W-1:0]         phase,
  input  logic [1:0]                 instru,
  output logic signed [SAMPLE_W-1:0] wave
);

  localparam logic signed [SAMPLE_W-1:0] FS =
    {1'b0, {(SAMPLE_W-1){1'b1}}};

  logic [SAMPLE_W-1:0] t;
  logic                msb;
  logic [SAMPLE_W-2:0] f;

  assign t   = phase[PHASE_W-1 -: SAMPLE_W];
  assign msb = t[SAMPLE_W-1];
  assign f   = msb ? ~t[SAMPLE_W-2:0] : t[SAMPLE_W-2:0];

  // triangle is {f,0} with its msb flipped to centre it on zero
  always_comb begin
    wave = '0;
    unique case (wave_e'(instru))
      WAVE_SQUARE: wave = msb ? -FS : FS;
      WAVE_SAW:    wave = {~msb, t[SAMPLE_W-2:0]};
      WAVE_TRI:    wave = {~f[SAMPLE_W-2], f[SAMPLE_W-3:0], 1'b0};
      WAVE_OFF:    wave = '0;
    endcase
  end

endmodule

// File: rtl/poly_tone_mixer.sv
// N-voice time-multiplexed tone generator and saturating mixer.
// Define POLY_TONE_ENV_EN for attack/release envelopes; otherwise voices are gated on/off.
module poly_tone_mixer
  import synth_pkg::*;
#(
  parameter int NUM_CH       = 4,
  parameter int PHASE_W      = 24,
  parameter int SAMPLE_W     = 16,
  parameter int ENV_W        = 8,
  parameter int ATTACK_STEP  = 8,
  parameter int RELEASE_STEP = 2
) (
  input  logic                      iCLK,
  input  logic                      iRST_N,
  input  logic                      iTick,
  input  logic [NUM_CH*PHASE_W-1:0] iFreqInc,
  input  logic [NUM_CH-1:0]         iGate,
  input  logic [1:0]                iInstru,
  output logic signed [SAMPLE_W-1:0] oSample,
  output logic                      oValid,
  output logic [NUM_CH-1:0]         oActive,
  output logic                      oOverrun
);

  localparam int CH_W  = (NUM_CH > 1) ? clog2(NUM_CH) : 1;
  localparam int ACC_W = SAMPLE_W + clog2(NUM_CH) + 1;
  localparam logic [CH_W-1:0]  CH_LAST = CH_W'(NUM_CH - 1);
  localparam logic [ENV_W-1:0] LVL_MAX = '1;
  localparam logic signed [ACC_W-1:0] S_MAX =
    {{(ACC_W-SAMPLE_W+1){1'b0}}, {(SAMPLE_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] S_MIN = ~S_MAX;

  state_e state_q, state_d;
  logic [CH_W-1:0] ch_q, ch_d;

  logic [PHASE_W-1:0] phase_q [NUM_CH];
  logic [NUM_CH-1:0]  gate_q;
  logic signed [ACC_W-1:0]    acc_q;
  logic signed [SAMPLE_W-1:0] scaled_q;

  logic [PHASE_W-1:0] inc_arr [NUM_CH];
  logic [PHASE_W-1:0] inc, phase_new;
  logic               gate, rise;
  logic [ENV_W-1:0]   level_new;
  logic signed [SAMPLE_W-1:0] wave, scaled;
  logic signed [SAMPLE_W-1:0] clamped;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_inc
    assign inc_arr[g] = iFreqInc[g*PHASE_W +: PHASE_W];
  end

  assign inc       = inc_arr[ch_q];
  assign gate      = iGate[ch_q];
  assign rise      = gate & ~gate_q[ch_q];
  assign phase_new = rise ? '0 : phase_q[ch_q] + inc;

  tone_wave_shaper #(
    .PHASE_W  (PHASE_W),
    .SAMPLE_W (SAMPLE_W)
  ) u_shaper (
    .phase  (phase_new),
    .instru (iInstru),
    .wave   (wave)
  );

`ifdef POLY_TONE_ENV_EN
  logic [ENV_W-1:0] level_q [NUM_CH];
  logic [ENV_W-1:0] lvl;
  logic signed [SAMPLE_W+ENV_W:0] prod;

  assign lvl = level_q[ch_q];

  // saturating ramp towards full scale or zero
  always_comb begin
    level_new = lvl;
    if (gate) begin
      if (LVL_MAX - lvl < ENV_W'(ATTACK_STEP)) level_new = LVL_MAX;
      else level_new = lvl + ENV_W'(ATTACK_STEP);
    end else begin
      if (lvl < ENV_W'(RELEASE_STEP)) level_new = '0;
      else level_new = lvl - ENV_W'(RELEASE_STEP);
    end
  end

  assign prod   = wave * $signed({1'b0, level_new});
  assign scaled = SAMPLE_W'(prod >>> ENV_W);

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      for (int i = 0; i < NUM_CH; i++) level_q[i] <= '0;
    end else if (state_q == ST_CALC) begin
      level_q[ch_q] <= level_new;
    end
  end
`else
  assign level_new = gate ? LVL_MAX : '0;
  assign scaled    = gate ? wave : '0;
`endif

  always_comb begin
    clamped = acc_q[SAMPLE_W-1:0];
    if (acc_q > S_MAX)      clamped = S_MAX[SAMPLE_W-1:0];
    else if (acc_q < S_MIN) clamped = S_MIN[SAMPLE_W-1:0];
  end

  always_comb begin
    state_d = state_q;
    ch_d    = ch_q;
    unique case (state_q)
      ST_IDLE: begin
        if (iTick) begin
          state_d = ST_CALC;
          ch_d    = '0;
        end
      end
      ST_CALC: state_d = ST_ADD;
      ST_ADD: begin
        if (ch_q == CH_LAST) begin
          state_d = ST_OUT;
        end else begin
          state_d = ST_CALC;
          ch_d    = ch_q + 1'b1;
        end
      end
      ST_OUT: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state_q  <= ST_IDLE;
      ch_q     <= '0;
      acc_q    <= '0;
      scaled_q <= '0;
      gate_q   <= '0;
      oSample  <= '0;
      oValid   <= 1'b0;
      oActive  <= '0;
      oOverrun <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) phase_q[i] <= '0;
    end else begin
      state_q <= state_d;
      ch_q    <= ch_d;
      oValid  <= 1'b0;
      if (iTick && state_q != ST_IDLE) oOverrun <= 1'b1;
      unique case (state_q)
        ST_IDLE: acc_q <= '0;
        ST_CALC: begin
          phase_q[ch_q] <= phase_new;
          gate_q[ch_q]  <= gate;
          oActive[ch_q] <= (level_new != '0);
          scaled_q      <= scaled;
        end
        ST_ADD: acc_q <= acc_q + ACC_W'(scaled_q);
        ST_OUT: begin
          oSample <= clamped;
          oValid  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_poly_tone_mixer.sv
// Self-checking bench for poly_tone_mixer: vector table, hand sequences, random vs model.
// Follows POLY_TONE_ENV_EN the same way as the design.
module tb_poly_tone_mixer;
  import synth_pkg::*;

  localparam int NC = 2;
  localparam int PW = 24;
  localparam int SW = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic tick = 1'b0;
  logic [NC*PW-1:0] freq = '0;
  logic [NC-1:0] gate = '0;
  logic [1:0] instru = 2'b00;
  logic signed [SW-1:0] samp;
  logic valid;
  logic [NC-1:0] active;
  logic overrun;

  int n_tests = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  poly_tone_mixer #(.NUM_CH(NC), .PHASE_W(PW), .SAMPLE_W(SW)) dut (
    .iCLK(clk), .iRST_N(rst_n), .iTick(tick), .iFreqInc(freq),
    .iGate(gate), .iInstru(instru), .oSample(samp), .oValid(valid),
    .oActive(active), .oOverrun(overrun)
  );

  longint m_ph[NC];
  int m_lv[NC];
  bit m_g[NC];

  task automatic check(input string nm, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic int wave_of(input int t, input logic [1:0] ins);
    int f;
    case (ins)
      2'b00: return (t >= 32768) ? -32767 : 32767;
      2'b01: return t - 32768;
      2'b10: begin
        f = (t >= 32768) ? 32767 - (t - 32768) : t;
        return 2 * f - 32768;
      end
      default: return 0;
    endcase
  endfunction

  task automatic model_reset();
    for (int c = 0; c < NC; c++) begin
      m_ph[c] = 0; m_lv[c] = 0; m_g[c] = 0;
    end
  endtask

  task automatic model_tick(input logic [1:0] ins, input logic [NC-1:0] g,
                            input logic [NC*PW-1:0] inc,
                            output int s, output logic [NC-1:0] act);
    longint sum, i;
    int w, sc;
    sum = 0;
    act = '0;
    for (int c = 0; c < NC; c++) begin
      i = longint'(inc[c*PW +: PW]);
      if (g[c] && !m_g[c]) m_ph[c] = 0;
      else m_ph[c] = (m_ph[c] + i) % (longint'(1) << PW);
      m_g[c] = g[c];
`ifdef POLY_TONE_ENV_EN
      if (g[c]) m_lv[c] = (m_lv[c] + 8 > 255) ? 255 : m_lv[c] + 8;
      else m_lv[c] = (m_lv[c] - 2 < 0) ? 0 : m_lv[c] - 2;
`else
      m_lv[c] = g[c] ? 255 : 0;
`endif
      w = wave_of(int'(m_ph[c] >> (PW - SW)), ins);
`ifdef POLY_TONE_ENV_EN
      sc = (w * m_lv[c]) >>> 8;
`else
      sc = g[c] ? w : 0;
`endif
      sum += sc;
      act[c] = (m_lv[c] != 0);
    end
    if (sum > 32767) s = 32767;
    else if (sum < -32768) s = -32768;
    else s = int'(sum);
  endtask

  task automatic run_tick(input logic [1:0] ins, input logic [NC-1:0] g,
                          input logic [NC*PW-1:0] inc,
                          output int s, output int lat);
    @(negedge clk);
    instru = ins; gate = g; freq = inc; tick = 1'b1;
    @(posedge clk); #1 tick = 1'b0;
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!valid && lat < 50);
    s = int'(samp);
  endtask

  task automatic do_tick(input string nm, input logic [1:0] ins,
                         input logic [NC-1:0] g, input logic [NC*PW-1:0] inc,
                         output int s);
    int e, lat;
    logic [NC-1:0] a;
    model_tick(ins, g, inc, e, a);
    run_tick(ins, g, inc, s, lat);
    check({nm, "_smp"}, s, e);
    check({nm, "_act"}, int'(active), int'(a));
  endtask

  typedef struct {
    logic [1:0]    ins;
    logic [NC-1:0] g;
    logic [PW-1:0] inc0;
    logic [PW-1:0] inc1;
    int            exp;
  } vec_t;

  vec_t vt[12];

  initial begin
    int s, e, lat, cnt, os;
    logic [NC-1:0] a;

    vt[0]  = '{2'b00, 2'b11, 24'h0,      24'h0,      32767};
    vt[1]  = '{2'b00, 2'b11, 24'h0,      24'h0,      32767};
    vt[2]  = '{2'b01, 2'b01, 24'h100000, 24'h0,     -28672};
    vt[3]  = '{2'b01, 2'b01, 24'h100000, 24'h0,     -24576};
    vt[4]  = '{2'b10, 2'b01, 24'h100000, 24'h0,      -8192};
    vt[5]  = '{2'b11, 2'b11, 24'h0,      24'h0,          0};
    vt[6]  = '{2'b00, 2'b10, 24'h0,      24'h800000,-32767};
    vt[7]  = '{2'b00, 2'b10, 24'h0,      24'h800000, 32767};
    vt[8]  = '{2'b00, 2'b11, 24'h0,      24'h800000,     0};
    vt[9]  = '{2'b10, 2'b01, 24'h0,      24'h0,     -32768};
    vt[10] = '{2'b00, 2'b11, 24'h800000, 24'h800000,     0};
    vt[11] = '{2'b00, 2'b11, 24'h0,      24'h800000,-32768};

    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("rst_sample", int'(samp), 0);
    check("rst_valid", int'(valid), 0);
    check("rst_active", int'(active), 0);
    check("rst_overrun", int'(overrun), 0);
    @(negedge clk) rst_n = 1'b1;

    for (int i = 0; i < 12; i++) begin
      model_tick(vt[i].ins, vt[i].g, {vt[i].inc1, vt[i].inc0}, e, a);
      run_tick(vt[i].ins, vt[i].g, {vt[i].inc1, vt[i].inc0}, s, lat);
`ifndef POLY_TONE_ENV_EN
      e = vt[i].exp;
`endif
      check($sformatf("tbl%0d_smp", i), s, e);
      check($sformatf("tbl%0d_act", i), int'(active), int'(a));
      check($sformatf("tbl%0d_lat", i), lat, 2 * NC + 1);
    end
    @(posedge clk); #1;
    check("valid_width", int'(valid), 0);
    check("overrun_idle", int'(overrun), 0);

    // gate re-rise mid-cycle restarts phase
    for (int k = 0; k < 3; k++)
      do_tick("rr_run", 2'b10, 2'b01, {24'h0, 24'h123456}, s);
    do_tick("rr_off", 2'b10, 2'b00, {24'h0, 24'h123456}, s);
    do_tick("rr_rise", 2'b10, 2'b01, {24'h0, 24'h123456}, s);
`ifndef POLY_TONE_ENV_EN
    check("rr_tri", s, -32768);
`endif

    // second tick while busy: ignored, sticky overrun
    model_tick(2'b01, 2'b11, {24'h0A0000, 24'h050000}, e, a);
    @(negedge clk);
    instru = 2'b01; gate = 2'b11; freq = {24'h0A0000, 24'h050000};
    tick = 1'b1;
    @(posedge clk); #1 tick = 1'b0;
    @(posedge clk);
    @(negedge clk) tick = 1'b1;
    @(posedge clk); #1 tick = 1'b0;
    cnt = 0; os = 0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      if (valid) begin cnt++; os = int'(samp); end
    end
    check("ovr_pulses", cnt, 1);
    check("ovr_sample", os, e);
    check("ovr_flag", int'(overrun), 1);

    for (int k = 0; k < 40; k++) begin
      logic [1:0] ri;
      logic [NC-1:0] rg;
      logic [NC*PW-1:0] rf;
      ri = 2'($urandom_range(0, 3));
      rg = NC'($urandom);
      for (int c = 0; c < NC; c++)
        rf[c*PW +: PW] = PW'($urandom);
      do_tick($sformatf("rnd%0d", k), ri, rg, rf, s);
    end
    check("ovr_sticky", int'(overrun), 1);

`ifdef POLY_TONE_ENV_EN
    for (int k = 0; k < 32; k++)
      do_tick($sformatf("att%0d", k), 2'b00, 2'b01, '0, s);
    check("att_full", s, (32767 * 255) >>> 8);
    for (int k = 0; k < 130; k++)
      do_tick($sformatf("rel%0d", k), 2'b00, 2'b00, '0, s);
    check("rel_idle", int'(active), 0);
`endif

    // reset in the middle of a frame
    do_tick("pre_rst", 2'b00, 2'b11, '0, s);
    @(negedge clk);
    tick = 1'b1;
    @(posedge clk); #1 tick = 1'b0;
    @(posedge clk);
    @(negedge clk) rst_n = 1'b0;
    #1;
    check("mid_rst_sample", int'(samp), 0);
    check("mid_rst_valid", int'(valid), 0);
    check("mid_rst_active", int'(active), 0);
    check("mid_rst_overrun", int'(overrun), 0);
    @(negedge clk) rst_n = 1'b1;
    model_reset();
    cnt = 0;
    for (int k = 0; k < 15; k++) begin
      @(posedge clk); #1;
      if (valid) cnt++;
    end
    check("post_rst_novalid", cnt, 0);
    do_tick("post_rst", 2'b01, 2'b11, {24'h0, 24'h0}, s);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
